bp_fe_mem_cmd_sched: RTL and testbench

// Sequences and arbitrates the single FE memory command port (fetch / icache fence / itlb fence /

---
 rtl/bp_fe_mem_cmd_sched.sv | 156 +++++++++++++++
 tb/tb_bp_fe_mem_cmd_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_mem_cmd_sched.sv
// Front-end memory command scheduler: arbitrates fetch, itlb fill and fence commands onto the
// single FE mem port, tracks in-flight fetches, drains before fences and halts fetch after a miss.
module bp_fe_mem_cmd_sched #(
  parameter int vaddr_width_p     = 39,
  parameter int vtag_width_p      = 27,
  parameter int tlb_entry_width_p = 40,
  parameter int resp_latency_p    = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         fetch_v_i,
  input  logic [vaddr_width_p-1:0]     fetch_vaddr_i,
  output logic                         fetch_yumi_o,
  input  logic                         fill_v_i,
  input  logic [vtag_width_p-1:0]      fill_vtag_i,
  input  logic [tlb_entry_width_p-1:0] fill_entry_i,
  output logic                         fill_ready_o,
  input  logic                         fence_v_i,
  input  logic                         fence_itlb_i,
  output logic                         fence_ready_o,
  input  logic                         redirect_i,
  output logic                         mem_cmd_v_o,
  output logic [1:0]                   mem_cmd_op_o,
  output logic [vaddr_width_p-1:0]     mem_cmd_vaddr_o,
  output logic [vtag_width_p-1:0]      mem_cmd_vtag_o,
  output logic [tlb_entry_width_p-1:0] mem_cmd_entry_o,
  input  logic                         mem_cmd_yumi_i,
  output logic                         mem_poison_o,
  input  logic                         mem_resp_v_i,
  input  logic                         mem_resp_miss_i,
  output logic                         halted_o
);

  localparam int cnt_w_lp = $clog2(resp_latency_p + 1);
  localparam logic [cnt_w_lp-1:0] max_inflight_lp = cnt_w_lp'(resp_latency_p);
  localparam logic [cnt_w_lp-1:0] one_lp          = cnt_w_lp'(1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FENCE = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [1:0] OP_FETCH  = 2'd0;
  localparam logic [1:0] OP_IFENCE = 2'd1;
  localparam logic [1:0] OP_TFENCE = 2'd2;
  localparam logic [1:0] OP_FILL   = 2'd3;

  logic [1:0]                   state_q, state_d;
  logic                         fill_full_q, fill_full_d;
  logic [vtag_width_p-1:0]      fill_vtag_q, fill_vtag_d;
  logic [tlb_entry_width_p-1:0] fill_entry_q, fill_entry_d;
  logic                         fence_full_q, fence_full_d;
  logic                         fence_itlb_q, fence_itlb_d;
  logic [cnt_w_lp-1:0]          inflight_q, inflight_d;

  logic sel_fence, sel_fill, sel_fetch;
  logic fetch_fire, fill_done, fence_done;
  logic resp_ok, miss_ok;

  // Every select is qualified by reset so all outputs read 0 while reset is held.
  always_comb begin
    sel_fence  = reset_n_i & (state_q == ST_FENCE) & fence_full_q;
    sel_fill   = reset_n_i & fill_full_q & (state_q != ST_FENCE);
    sel_fetch  = reset_n_i & ~sel_fill & (state_q == ST_RUN) & ~fence_full_q & fetch_v_i
               & (inflight_q < max_inflight_lp) & ~redirect_i;
    fetch_fire = sel_fetch & mem_cmd_yumi_i;
    fill_done  = sel_fill & mem_cmd_yumi_i;
    fence_done = sel_fence & mem_cmd_yumi_i;
    // A response with nothing outstanding is spurious and must not count or halt.
    resp_ok    = mem_resp_v_i & (inflight_q != '0);
    miss_ok    = resp_ok & mem_resp_miss_i & ~redirect_i;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    fill_full_d  = fill_full_q;
    fill_vtag_d  = fill_vtag_q;
    fill_entry_d = fill_entry_q;
    fence_full_d = fence_full_q;
    fence_itlb_d = fence_itlb_q;
    inflight_d   = inflight_q;
    state_d      = state_q;

    if (fill_done) begin
      fill_full_d = 1'b0;
    end else if (fill_v_i & ~fill_full_q) begin
      fill_full_d  = 1'b1;
      fill_vtag_d  = fill_vtag_i;
      fill_entry_d = fill_entry_i;
    end

    if (fence_done) begin
      fence_full_d = 1'b0;
    end else if (fence_v_i & ~fence_full_q) begin
      fence_full_d = 1'b1;
      fence_itlb_d = fence_itlb_i;
    end

    if (redirect_i) begin
      inflight_d = '0;
    end else if (fetch_fire & ~resp_ok) begin
      inflight_d = inflight_q + one_lp;
    end else if (~fetch_fire & resp_ok) begin
      inflight_d = inflight_q - one_lp;
    end

    // DRAIN looks at the next count so the fence goes out the cycle after the last response.
    unique case (state_q)
      ST_RUN: begin
        if (fence_full_q)  state_d = ST_DRAIN;
        else if (miss_ok)  state_d = ST_HALT;
      end
      ST_DRAIN: if (inflight_d == '0) state_d = ST_FENCE;
      ST_FENCE: if (fence_done)       state_d = ST_RUN;
      ST_HALT: begin
        if (fence_full_q)                 state_d = ST_DRAIN;
        else if (redirect_i | fill_done)  state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_RUN;
      fill_full_q  <= 1'b0;
      fill_vtag_q  <= '0;
      fill_entry_q <= '0;
      fence_full_q <= 1'b0;
      fence_itlb_q <= 1'b0;
      inflight_q   <= '0;
    end else begin
      state_q      <= state_d;
      fill_full_q  <= fill_full_d;
      fill_vtag_q  <= fill_vtag_d;
      fill_entry_q <= fill_entry_d;
      fence_full_q <= fence_full_d;
      fence_itlb_q <= fence_itlb_d;
      inflight_q   <= inflight_d;
    end
  end

  assign mem_cmd_v_o     = sel_fence | sel_fill | sel_fetch;
  assign mem_cmd_op_o    = sel_fence ? (fence_itlb_q ? OP_TFENCE : OP_IFENCE)
                         : sel_fill  ? OP_FILL : OP_FETCH;
  assign mem_cmd_vaddr_o = sel_fetch ? fetch_vaddr_i : '0;
  assign mem_cmd_vtag_o  = sel_fill ? fill_vtag_q : '0;
  assign mem_cmd_entry_o = sel_fill ? fill_entry_q : '0;
  assign fetch_yumi_o    = fetch_fire;
  assign fill_ready_o    = reset_n_i & ~fill_full_q;
  assign fence_ready_o   = reset_n_i & ~fence_full_q;
  assign mem_poison_o    = reset_n_i & redirect_i;
  assign halted_o        = reset_n_i & (state_q == ST_HALT);

endmodule

// File: tb/tb_bp_fe_mem_cmd_sched.sv
// Bench for bp_fe_mem_cmd_sched: directed scenarios then random traffic, scored against a
// transaction-level model whose outstanding fetches live in a queue of response due-cycles.
module tb_bp_fe_mem_cmd_sched;

  localparam int VA  = 39;
  localparam int VT  = 27;
  localparam int TE  = 40;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          fetch_v_i = 1'b0, fill_v_i = 1'b0, fence_v_i = 1'b0, fence_itlb_i = 1'b0;
  logic          redirect_i = 1'b0, mem_cmd_yumi_i = 1'b0, mem_resp_v_i = 1'b0, mem_resp_miss_i = 1'b0;
  logic [VA-1:0] fetch_vaddr_i = '0;
  logic [VT-1:0] fill_vtag_i = '0;
  logic [TE-1:0] fill_entry_i = '0;
  logic          fetch_yumi_o, fill_ready_o, fence_ready_o, mem_cmd_v_o, mem_poison_o, halted_o;
  logic [1:0]    mem_cmd_op_o;
  logic [VA-1:0] mem_cmd_vaddr_o;
  logic [VT-1:0] mem_cmd_vtag_o;
  logic [TE-1:0] mem_cmd_entry_o;

  bp_fe_mem_cmd_sched #(
    .vaddr_width_p(VA), .vtag_width_p(VT), .tlb_entry_width_p(TE), .resp_latency_p(LAT)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .fetch_v_i(fetch_v_i), .fetch_vaddr_i(fetch_vaddr_i), .fetch_yumi_o(fetch_yumi_o),
    .fill_v_i(fill_v_i), .fill_vtag_i(fill_vtag_i), .fill_entry_i(fill_entry_i),
    .fill_ready_o(fill_ready_o),
    .fence_v_i(fence_v_i), .fence_itlb_i(fence_itlb_i), .fence_ready_o(fence_ready_o),
    .redirect_i(redirect_i),
    .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_op_o(mem_cmd_op_o), .mem_cmd_vaddr_o(mem_cmd_vaddr_o),
    .mem_cmd_vtag_o(mem_cmd_vtag_o), .mem_cmd_entry_o(mem_cmd_entry_o),
    .mem_cmd_yumi_i(mem_cmd_yumi_i), .mem_poison_o(mem_poison_o),
    .mem_resp_v_i(mem_resp_v_i), .mem_resp_miss_i(mem_resp_miss_i), .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          cmd_v;
    logic [1:0]    op;
    logic [VA-1:0] vaddr;
    logic [VT-1:0] vtag;
    logic [TE-1:0] entry;
    logic          fetch_yumi;
    logic          fill_ready;
    logic          fence_ready;
    logic          poison;
    logic          halted;
  } obs_t;

  typedef enum {M_NORMAL, M_WAIT_EMPTY, M_DO_FENCE, M_STALLED} mode_t;

  // Reference model state.
  mode_t         m_mode;
  bit            m_fill_full, m_fence_full, m_fence_itlb;
  logic [VT-1:0] m_fill_vtag;
  logic [TE-1:0] m_fill_entry;
  int            pend[$];
  int            cyc = 0;
  int            miss_pct = 25;
  int            spur_pct = 5;

  // Decisions of the current cycle, applied at the next rising edge.
  bit s_fetch, s_fill, s_fence, s_counted, s_redir, s_yumi, s_flv, s_fcv, s_itlb, s_miss;
  logic [VT-1:0] s_vtag;
  logic [TE-1:0] s_entry;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic obs_t sample();
    obs_t o;
    o.cmd_v       = mem_cmd_v_o;
    o.op          = mem_cmd_op_o;
    o.vaddr       = mem_cmd_vaddr_o;
    o.vtag        = mem_cmd_vtag_o;
    o.entry       = mem_cmd_entry_o;
    o.fetch_yumi  = fetch_yumi_o;
    o.fill_ready  = fill_ready_o;
    o.fence_ready = fence_ready_o;
    o.poison      = mem_poison_o;
    o.halted      = halted_o;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got v=%0b op=%0d va=%h vt=%h yumi=%0b rdy=%0b%0b poison=%0b halt=%0b, expected v=%0b op=%0d va=%h vt=%h yumi=%0b rdy=%0b%0b poison=%0b halt=%0b",
               name, $time, got.cmd_v, got.op, got.vaddr, got.vtag, got.fetch_yumi,
               got.fill_ready, got.fence_ready, got.poison, got.halted,
               exp.cmd_v, exp.op, exp.vaddr, exp.vtag, exp.fetch_yumi,
               exp.fill_ready, exp.fence_ready, exp.poison, exp.halted);
    end
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) check("cycle", sample(), exp_q.pop_front());
  end

  task automatic model_reset();
    m_mode       = M_NORMAL;
    m_fill_full  = 0;
    m_fence_full = 0;
    m_fence_itlb = 0;
    m_fill_vtag  = '0;
    m_fill_entry = '0;
    pend.delete();
  endtask

  // Drives one cycle of stimulus, predicts the DUT response, then advances the model at the edge.
  task automatic drive(input bit fv, input logic [VA-1:0] va, input bit flv, input logic [VT-1:0] vt,
                       input bit fcv, input bit itlb, input bit redir, input bit yumi);
    obs_t e;
    bit   due, spur;
    int   outstanding;
    logic [TE-1:0] en;
    en          = TE'({$urandom(), $urandom()});
    outstanding = pend.size();
    due         = (outstanding > 0) && (pend[0] == cyc);
    spur        = (outstanding == 0) && ($urandom_range(0, 99) < spur_pct);

    fetch_v_i = fv;   fetch_vaddr_i = va;
    fill_v_i = flv;   fill_vtag_i = vt;   fill_entry_i = en;
    fence_v_i = fcv;  fence_itlb_i = itlb;
    redirect_i = redir;
    mem_cmd_yumi_i = yumi;
    mem_resp_v_i = due | spur;
    mem_resp_miss_i = (due | spur) && ($urandom_range(0, 99) < miss_pct);

    s_fence   = (m_mode == M_DO_FENCE) && m_fence_full;
    s_fill    = m_fill_full && !s_fence;
    s_fetch   = !s_fill && (m_mode == M_NORMAL) && !m_fence_full && fv && (outstanding < LAT) && !redir;
    s_counted = due;
    s_miss    = due && mem_resp_miss_i && !redir;
    s_redir = redir; s_yumi = yumi; s_flv = flv; s_fcv = fcv; s_itlb = itlb;
    s_vtag = vt; s_entry = en;

    e.cmd_v       = s_fence | s_fill | s_fetch;
    e.op          = s_fence ? (m_fence_itlb ? 2'd2 : 2'd1) : (s_fill ? 2'd3 : 2'd0);
    e.vaddr       = s_fetch ? va : '0;
    e.vtag        = s_fill ? m_fill_vtag : '0;
    e.entry       = s_fill ? m_fill_entry : '0;
    e.fetch_yumi  = s_fetch & yumi;
    e.fill_ready  = !m_fill_full;
    e.fence_ready = !m_fence_full;
    e.poison      = redir;
    e.halted      = (m_mode == M_STALLED);
    exp_q.push_back(e);

    @(posedge clk);
    if (s_counted) void'(pend.pop_front());
    if (s_redir) pend.delete();
    if (s_fetch && s_yumi) pend.push_back(cyc + LAT);

    case (m_mode)
      M_NORMAL:     if (m_fence_full) m_mode = M_WAIT_EMPTY; else if (s_miss) m_mode = M_STALLED;
      M_WAIT_EMPTY: if (pend.size() == 0) m_mode = M_DO_FENCE;
      M_DO_FENCE:   if (s_fence && s_yumi) m_mode = M_NORMAL;
      M_STALLED: begin
        if (m_fence_full) m_mode = M_WAIT_EMPTY;
        else if (s_redir || (s_fill && s_yumi)) m_mode = M_NORMAL;
      end
      default: m_mode = M_NORMAL;
    endcase

    if (s_fill && s_yumi) m_fill_full = 0;
    else if (s_flv && !m_fill_full) begin
      m_fill_full = 1; m_fill_vtag = s_vtag; m_fill_entry = s_entry;
    end
    if (s_fence && s_yumi) m_fence_full = 0;
    else if (s_fcv && !m_fence_full) begin
      m_fence_full = 1; m_fence_itlb = s_itlb;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input bit fv);
    for (int i = 0; i < n; i++) drive(fv, 39'h5000 + VA'(i * 4), 0, '0, 0, 0, 0, 1);
  endtask

  initial begin
    logic [VA-1:0] addrs [3];
    int tries;
    addrs[0] = 39'h1000; addrs[1] = 39'h1004; addrs[2] = 39'h1008;
    model_reset();

    // Outputs stay at zero while reset is held, even with active inputs.
    fetch_v_i = 1; fill_v_i = 1; fence_v_i = 1; redirect_i = 1; mem_cmd_yumi_i = 1;
    @(posedge clk); @(posedge clk); #1;
    check("reset_hold", sample(), '0);
    fetch_v_i = 0; fill_v_i = 0; fence_v_i = 0; redirect_i = 0; mem_cmd_yumi_i = 0;
    reset_n_i = 1;

    // Back-to-back fetches; the third must wait for the first response.
    miss_pct = 0; spur_pct = 0;
    for (int k = 0; k < 3; k++) begin
      tries = 0;
      do begin
        drive(1, addrs[k], 0, '0, 0, 0, 0, 1);
        tries++;
      end while (!(s_fetch && s_yumi) && tries < 10);
    end
    idle(3, 0);

    // itlb fence with two fetches outstanding.
    drive(1, 39'h2000, 0, '0, 0, 0, 0, 1);
    drive(1, 39'h2004, 0, '0, 1, 1, 0, 1);
    idle(6, 1);

    // Miss response halts fetch until a fill is accepted.
    miss_pct = 100;
    drive(1, 39'h3000, 0, '0, 0, 0, 0, 1);
    miss_pct = 0;
    idle(4, 1);
    drive(1, 39'h3004, 1, 27'h12, 0, 0, 0, 1);
    idle(4, 1);

    // Redirect while draining for a fence.
    drive(1, 39'h4000, 0, '0, 1, 0, 0, 1);
    drive(1, 39'h4004, 0, '0, 0, 0, 0, 1);
    drive(1, 39'h4008, 0, '0, 0, 0, 1, 1);
    idle(4, 1);

    // Fill and fetch arriving together.
    drive(1, 39'h6000, 1, 27'h5a5, 0, 0, 0, 1);
    drive(1, 39'h6004, 0, '0, 0, 0, 0, 1);
    idle(3, 1);

    // Asynchronous reset in the middle of an accepted fetch.
    drive(1, 39'h7000, 0, '0, 0, 0, 0, 1);
    fetch_v_i = 1; mem_cmd_yumi_i = 1; fetch_vaddr_i = 39'h7004;
    @(negedge clk); #2;
    reset_n_i = 0;
    #1 check("reset_async", sample(), '0);
    @(posedge clk);
    model_reset();
    #1 reset_n_i = 1;
    idle(4, 1);

    // Random traffic.
    miss_pct = 25; spur_pct = 5;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, VA'({$urandom(), $urandom()}),
            $urandom_range(0, 99) < 8, VT'($urandom()),
            $urandom_range(0, 99) < 4, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 5, $urandom_range(0, 3) != 0);
    end
    fetch_v_i = 0; fill_v_i = 0; fence_v_i = 0; redirect_i = 0;
    @(negedge clk); @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
